sal_ref_ctrl: RTL

SAL_REF_CTRL -- requirements
Module: sal_ref_ctrl

---
 rtl/sal_ref_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/sal_ref_ctrl.sv
// Refresh scheduler: interval ticks accumulate into a pending count that is drained
// through a REQ/GNT handshake, then held busy for tRFC. Optional: SAL_REF_POSTPONE_EN.
module sal_ref_ctrl #(
    parameter int unsigned TREFI_W = 16,
    parameter int unsigned TRFC_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ref_en_i,
    input  logic [TREFI_W-1:0] trefi_i,
    input  logic [TRFC_W-1:0]  trfc_i,
    output logic               ref_req_o,
    input  logic               ref_gnt_i,
    output logic               ref_busy_o,
    output logic               ref_urgent_o,
    output logic [3:0]         ref_pend_o,
    output logic               ref_ovf_o
);

`ifdef SAL_REF_POSTPONE_EN
    localparam logic [3:0] PMAX = 4'd8;
    localparam logic [3:0] UTH  = 4'd6;
`else
    localparam logic [3:0] PMAX = 4'd1;
    localparam logic [3:0] UTH  = 4'd1;
`endif

    typedef enum logic [1:0] {StIdle, StReq, StRfc} state_e;

    state_e             state_q, state_d;
    logic [TREFI_W-1:0] ivl_q, ivl_d, trefi_m1;
    logic [TRFC_W-1:0]  rfc_q, rfc_d, trfc_m1;
    logic [3:0]         pend_q, pend_d;
    logic               ovf_q, ovf_d;
    logic               req_q, busy_q, urgent_q;
    logic               tick, grant;

    // A zero interval/window is treated as one cycle.
    assign trefi_m1 = (trefi_i == '0) ? '0 : trefi_i - 1'b1;
    assign trfc_m1  = (trfc_i == '0) ? '0 : trfc_i - 1'b1;

    assign tick  = ref_en_i && (ivl_q == '0);
    assign grant = (state_q == StReq) && ref_gnt_i;

    always_comb begin
        ivl_d = ivl_q - 1'b1;
        if (!ref_en_i || (ivl_q == '0)) begin
            ivl_d = trefi_m1;
        end
    end

    always_comb begin
        state_d = state_q;
        rfc_d   = rfc_q;
        unique case (state_q)
            StIdle: begin
                if (pend_q != 4'd0) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (ref_gnt_i) begin
                    state_d = StRfc;
                    rfc_d   = trfc_m1;
                end
            end
            StRfc: begin
                if (rfc_q == '0) begin
                    state_d = StIdle;
                end else begin
                    rfc_d = rfc_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Tick and grant together cancel; a tick at capacity is lost and flagged.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (tick && !grant) begin
            if (pend_q >= PMAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 4'd1;
            end
        end else if (grant && !tick && (pend_q != 4'd0)) begin
            pend_d = pend_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            ivl_q    <= trefi_m1;
            rfc_q    <= '0;
            pend_q   <= 4'd0;
            ovf_q    <= 1'b0;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
            urgent_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ivl_q    <= ivl_d;
            rfc_q    <= rfc_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            req_q    <= (state_d == StReq);
            busy_q   <= (state_d == StRfc);
            urgent_q <= (pend_d >= UTH);
        end
    end

    assign ref_req_o    = req_q;
    assign ref_busy_o   = busy_q;
    assign ref_urgent_o = urgent_q;
    assign ref_pend_o   = pend_q;
    assign ref_ovf_o    = ovf_q;

endmodule
